// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared types and character constants for the sudoku frame loader
package sudoku_pkg;

  localparam int CELLS = 81;

  localparam logic [7:0] CH_START = 8'h53;
  localparam logic [7:0] CH_END   = 8'h45;
  localparam logic [7:0] CH_ACK   = 8'h4B;
  localparam logic [7:0] CH_NAK   = 8'h4E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CELLS,
    ST_WAIT_END,
    ST_ACK
  } state_e;

  typedef enum logic [2:0] {
    CC_START,
    CC_END,
    CC_DIGIT,
    CC_BLANK,
    CC_SKIP,
    CC_BAD
  } char_class_e;

endpackage

// File: rtl/sudoku_char_decode.sv
// rtl/sudoku_char_decode.sv - classifies one ASCII byte of a puzzle frame
module sudoku_char_decode
  import sudoku_pkg::*;
(
  input  logic [7:0]  data,
  output char_class_e cls,
  output logic [3:0]  value
);

  always_comb begin
    cls   = CC_BAD;
    value = 4'd0;
    if (data == CH_START) begin
      cls = CC_START;
    end else if (data == CH_END) begin
      cls = CC_END;
    end else if (data >= 8'h31 && data <= 8'h39) begin
      // ASCII '1'..'9' carry their digit in the low nibble
      cls   = CC_DIGIT;
      value = data[3:0];
    end else if (data == 8'h30 || data == 8'h2E) begin
      cls = CC_BLANK;
    end else if (data == 8'h20 || data == 8'h0D || data == 8'h0A || data == 8'h2C) begin
      cls = CC_SKIP;
    end
  end

endmodule

// File: rtl/sudoku_uart_loader.sv
// rtl/sudoku_uart_loader.sv - parses "S<81 cells>E" UART frames into board cell writes
// SUDOKU_LOADER_ECHO_EN enables a one-byte K/N acknowledge on the transmit stream.
module sudoku_uart_loader #(
  parameter int CELLS = sudoku_pkg::CELLS,
  parameter int IDX_W = 7
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [7:0]       from_uart_data,
  input  logic             from_uart_valid,
  input  logic             from_uart_error,
  output logic             from_uart_ready,
  output logic             cell_we,
  output logic [IDX_W-1:0] cell_addr,
  output logic [3:0]       cell_value,
  output logic             cell_fixed,
  input  logic             cell_ready,
  output logic             board_done,
  output logic             parse_error,
  output logic             busy,
  output logic [7:0]       to_uart_data,
  output logic             to_uart_valid,
  output logic             to_uart_error,
  input  logic             to_uart_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  sudoku_pkg::state_e      state;
  sudoku_pkg::char_class_e cls;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              dec_value;
  logic                    accept;
  logic                    do_start;
  logic                    do_write;
  logic                    do_done;
  logic                    do_err;

  sudoku_char_decode u_decode (
    .data  (from_uart_data),
    .cls   (cls),
    .value (dec_value)
  );

  assign from_uart_ready = !(cell_we && !cell_ready) && (state != sudoku_pkg::ST_ACK);
  assign accept          = from_uart_valid && from_uart_ready;
  assign busy            = (state != sudoku_pkg::ST_IDLE);
  assign to_uart_error   = 1'b0;

  // Errored bytes outside a frame are dropped like any other idle noise.
  always_comb begin
    do_start = 1'b0;
    do_write = 1'b0;
    do_done  = 1'b0;
    do_err   = 1'b0;
    if (accept) begin
      if (state == sudoku_pkg::ST_IDLE) begin
        do_start = !from_uart_error && (cls == sudoku_pkg::CC_START);
      end else if (from_uart_error) begin
        do_err = 1'b1;
      end else if (state == sudoku_pkg::ST_CELLS) begin
        case (cls)
          sudoku_pkg::CC_START: do_start = 1'b1;
          sudoku_pkg::CC_DIGIT,
          sudoku_pkg::CC_BLANK: do_write = 1'b1;
          sudoku_pkg::CC_SKIP:  ;
          default:              do_err   = 1'b1;
        endcase
      end else if (state == sudoku_pkg::ST_WAIT_END) begin
        case (cls)
          sudoku_pkg::CC_START: do_start = 1'b1;
          sudoku_pkg::CC_END:   do_done  = 1'b1;
          sudoku_pkg::CC_SKIP:  ;
          default:              do_err   = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state       <= sudoku_pkg::ST_IDLE;
      idx         <= '0;
      cell_we     <= 1'b0;
      cell_addr   <= '0;
      cell_value  <= 4'd0;
      cell_fixed  <= 1'b0;
      board_done  <= 1'b0;
      parse_error <= 1'b0;
`ifdef SUDOKU_LOADER_ECHO_EN
      to_uart_valid <= 1'b0;
      to_uart_data  <= 8'h00;
`endif
    end else begin
      board_done  <= do_done;
      parse_error <= do_err;

      if (cell_ready) begin
        cell_we <= 1'b0;
      end

      // A write loaded here overrides the drop above, keeping one cell per cycle.
      if (do_write) begin
        cell_we    <= 1'b1;
        cell_addr  <= idx;
        cell_value <= dec_value;
        cell_fixed <= (cls == sudoku_pkg::CC_DIGIT);
        if (idx == LAST_IDX) begin
          state <= sudoku_pkg::ST_WAIT_END;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end

      if (do_start) begin
        state <= sudoku_pkg::ST_CELLS;
        idx   <= '0;
      end

      if (do_done || do_err) begin
        idx <= '0;
`ifdef SUDOKU_LOADER_ECHO_EN
        state         <= sudoku_pkg::ST_ACK;
        to_uart_valid <= 1'b1;
        to_uart_data  <= do_done ? sudoku_pkg::CH_ACK : sudoku_pkg::CH_NAK;
`else
        state <= sudoku_pkg::ST_IDLE;
`endif
      end

`ifdef SUDOKU_LOADER_ECHO_EN
      if (state == sudoku_pkg::ST_ACK && to_uart_ready) begin
        state         <= sudoku_pkg::ST_IDLE;
        to_uart_valid <= 1'b0;
      end
`endif
    end
  end

`ifndef SUDOKU_LOADER_ECHO_EN
  logic unused_to_uart_ready;
  assign unused_to_uart_ready = to_uart_ready;
  assign to_uart_valid        = 1'b0;
  assign to_uart_data         = 8'h00;
`endif

endmodule

// File: tb/tb_sudoku_uart_loader.sv
// tb/tb_sudoku_uart_loader.sv - scoreboard bench for sudoku_uart_loader
module tb_sudoku_uart_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] from_uart_data;
  logic       from_uart_valid;
  logic       from_uart_error;
  logic       from_uart_ready;
  logic       cell_we;
  logic [6:0] cell_addr;
  logic [3:0] cell_value;
  logic       cell_fixed;
  logic       cell_ready;
  logic       board_done;
  logic       parse_error;
  logic       busy;
  logic [7:0] to_uart_data;
  logic       to_uart_valid;
  logic       to_uart_error;
  logic       to_uart_ready;

  always #5 clk = ~clk;

  sudoku_uart_loader #(.CELLS(81), .IDX_W(7)) dut (
    .clk_clk         (clk),
    .reset_reset     (reset),
    .from_uart_data  (from_uart_data),
    .from_uart_valid (from_uart_valid),
    .from_uart_error (from_uart_error),
    .from_uart_ready (from_uart_ready),
    .cell_we         (cell_we),
    .cell_addr       (cell_addr),
    .cell_value      (cell_value),
    .cell_fixed      (cell_fixed),
    .cell_ready      (cell_ready),
    .board_done      (board_done),
    .parse_error     (parse_error),
    .busy            (busy),
    .to_uart_data    (to_uart_data),
    .to_uart_valid   (to_uart_valid),
    .to_uart_error   (to_uart_error),
    .to_uart_ready   (to_uart_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef logic [11:0] wr_t;  // {addr, value, fixed}
  wr_t        cell_q[$];
  logic [7:0] ack_q[$];
  int         exp_idx    = 0;
  int         n_done     = 0;
  int         n_perr     = 0;
  int         rx_waits   = 0;
  int         stall_left = 0;
  bit         stall_arm  = 1'b0;
  int         ack_hold   = 0;
  wr_t        snap;
  string      puzzle = "530070000600195000098000060800060003400803001700020006060000280000419005000080079";

  // Single negedge process: drives both ready inputs and scores every output event.
  initial begin
    forever begin
      @(negedge clk);
      if (board_done) n_done++;
      if (parse_error) n_perr++;
      if (board_done && parse_error) chk("pulse_excl", 1, 0);

      if (stall_left > 0) begin
        chk("stall_we", {31'd0, cell_we}, 1);
        chk("stall_hold", {20'd0, cell_addr, cell_value, cell_fixed}, {20'd0, snap});
        chk("stall_rx_ready", {31'd0, from_uart_ready}, 0);
        stall_left--;
        cell_ready = (stall_left == 0);
      end else if (stall_arm && cell_we && cell_addr == 7'd10) begin
        snap       = {cell_addr, cell_value, cell_fixed};
        stall_arm  = 1'b0;
        stall_left = 3;
        cell_ready = 1'b0;
      end else begin
        cell_ready = 1'b1;
      end

      if (cell_we && cell_ready) begin
        if (cell_q.size() == 0) chk("unexpected_write", {25'd0, cell_addr}, 32'hFFFF);
        else chk("cell_write", {20'd0, cell_addr, cell_value, cell_fixed}, {20'd0, cell_q.pop_front()});
      end

      if (to_uart_valid) begin
        chk("ack_blocks_rx", {31'd0, from_uart_ready}, 0);
        if (ack_hold > 0) begin
          to_uart_ready = 1'b0;
          chk("ack_hold_data", {24'd0, to_uart_data}, 32'h4E);
          ack_hold--;
        end else begin
          to_uart_ready = 1'b1;
          if (ack_q.size() == 0) chk("ack_unexpected", {24'd0, to_uart_data}, 32'hFFFF);
          else chk("ack_data", {24'd0, to_uart_data}, {24'd0, ack_q.pop_front()});
        end
      end else begin
        to_uart_ready = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic e);
    int n = 0;
    from_uart_data  = b;
    from_uart_valid = 1'b1;
    from_uart_error = e;
    @(negedge clk); #1;
    while (!from_uart_ready && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    rx_waits += n;
    if (n >= 100) chk("rx_timeout", 1, 0);
    @(posedge clk); #1;
    from_uart_valid = 1'b0;
    from_uart_error = 1'b0;
  endtask

  task automatic send_cell(input logic [7:0] c);
    logic       f;
    logic [3:0] v;
    f = (c >= 8'h31 && c <= 8'h39);
    v = f ? c[3:0] : 4'd0;
    cell_q.push_back({exp_idx[6:0], v, f});
    exp_idx++;
    send_byte(c, 1'b0);
  endtask

  task automatic start_frame();
    exp_idx = 0;
    send_byte(8'h53, 1'b0);
  endtask

  task automatic send_puzzle(input int n, input bit crlf);
    for (int i = 0; i < n; i++) begin
      send_cell(puzzle[i]);
      if (crlf && (i % 9 == 8)) begin
        send_byte(8'h0D, 1'b0);
        send_byte(8'h0A, 1'b0);
      end
    end
  endtask

  task automatic end_frame(input logic [7:0] b, input logic e, input bit good);
`ifdef SUDOKU_LOADER_ECHO_EN
    ack_q.push_back(good ? 8'h4B : 8'h4E);
`endif
    send_byte(b, e);
    if (good) begin
      chk("done_pulse", {31'd0, board_done}, 1);
      chk("done_excl", {31'd0, parse_error}, 0);
    end else begin
      chk("perr_pulse", {31'd0, parse_error}, 1);
      chk("perr_excl", {31'd0, board_done}, 0);
    end
  endtask

  task automatic finish_scn(input string tag, input int done_exp, input int perr_exp);
    int n = 0;
    while ((busy || cell_we) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk({tag, "_drain_timeout"}, 1, 0);
    repeat (2) @(negedge clk);
    chk({tag, "_done_cnt"}, n_done, done_exp);
    chk({tag, "_perr_cnt"}, n_perr, perr_exp);
    chk({tag, "_cells_left"}, cell_q.size(), 0);
    chk({tag, "_acks_left"}, ack_q.size(), 0);
    n_done = 0;
    n_perr = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    from_uart_data  = 8'h00;
    from_uart_valid = 1'b0;
    from_uart_error = 1'b0;
    cell_ready      = 1'b1;
    to_uart_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cell_we", {31'd0, cell_we}, 0);
    chk("rst_cell_addr", {25'd0, cell_addr}, 0);
    chk("rst_done", {31'd0, board_done}, 0);
    chk("rst_perr", {31'd0, parse_error}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rx_ready", {31'd0, from_uart_ready}, 1);
    chk("rst_tx_valid", {31'd0, to_uart_valid}, 0);
    chk("rst_tx_error", {31'd0, to_uart_error}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Idle noise is dropped, then a clean frame streams one cell per cycle.
    send_byte(8'h78, 1'b0);
    send_byte(8'h35, 1'b0);
    chk("idle_busy", {31'd0, busy}, 0);
    start_frame();
    rx_waits = 0;
    send_puzzle(81, 1'b0);
    chk("no_stall", rx_waits, 0);
    end_frame(8'h45, 1'b0, 1'b1);
    finish_scn("full", 1, 0);

    start_frame();
    send_byte(8'h2C, 1'b0);
    send_puzzle(81, 1'b1);
    send_byte(8'h20, 1'b0);
    end_frame(8'h45, 1'b0, 1'b1);
    finish_scn("crlf", 1, 0);

    stall_arm = 1'b1;
    start_frame();
    send_puzzle(81, 1'b0);
    end_frame(8'h45, 1'b0, 1'b1);
    finish_scn("stall", 1, 0);
    chk("stall_seen", {31'd0, stall_arm}, 0);

`ifdef SUDOKU_LOADER_ECHO_EN
    ack_hold = 4;
`endif
    start_frame();
    send_puzzle(40, 1'b0);
    end_frame(8'h78, 1'b0, 1'b0);
    finish_scn("bad_char", 0, 1);
    chk("ack_hold_used", ack_hold, 0);

    start_frame();
    send_puzzle(20, 1'b0);
    start_frame();
    send_puzzle(81, 1'b0);
    end_frame(8'h45, 1'b0, 1'b1);
    finish_scn("restart", 1, 0);

    start_frame();
    send_puzzle(5, 1'b0);
    end_frame(8'h35, 1'b1, 1'b0);
    finish_scn("uart_err", 0, 1);

    start_frame();
    send_puzzle(3, 1'b0);
    end_frame(8'h45, 1'b0, 1'b0);
    finish_scn("early_end", 0, 1);

    start_frame();
    send_puzzle(81, 1'b0);
    end_frame(8'h37, 1'b0, 1'b0);
    finish_scn("extra_cell", 0, 1);

    start_frame();
    send_puzzle(10, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_we", {31'd0, cell_we}, 0);
    chk("mid_rst_cell", {20'd0, cell_addr, cell_value, cell_fixed}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_pulses", {30'd0, board_done, parse_error}, 0);
    chk("mid_rst_tx", {31'd0, to_uart_valid}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    finish_scn("reset", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
